csa_resolver: RTL

- Consumes the redundant sum/carry vector pair produced by the 64-bit carry-save 3:2 compressor stage.
- Converts the pair to a single binary word by carry-propagate addition.
- The addition is done serially, CHUNK bits per cycle, to keep the ripple path short.
- Sits between the CSA tree and any consumer that needs a binary result; uses valid/ready handshakes on both sides.

---
 rtl/csa_pkg.sv | 17 +
 rtl/csa_chunk_adder.sv | 28 ++
 rtl/fulladder.sv | 13 +
 rtl/csa_resolver.sv | 112 +++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared defaults, state encoding and chunk-count helper for the carry-save resolver.
package csa_pkg;

    localparam int CSA_WIDTH = 64;
    localparam int CSA_CHUNK = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    localparam int CSA_NCHUNK = nchunk(CSA_WIDTH, CSA_CHUNK);

endpackage

// File: rtl/csa_chunk_adder.sv
// CHUNK-bit ripple-carry adder built from fulladder cells.
// Latency: combinational. Backpressure: none.
module csa_chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;
    assign cout = c[CHUNK];

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell: combinational, no latency, no flow control.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/csa_resolver.sv
// Serial carry-propagate resolver for a carry-save sum/carry pair, CHUNK bits per cycle.
// Latency: WIDTH/CHUNK cycles accept-to-valid; with CSA_RESOLVE_ZERO_SKIP_EN, as low as 1.
// Backpressure: one operation in flight; in_ready low until the result is taken via out_ready.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int CHUNK = CSA_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow
);

    localparam int NCH  = nchunk(WIDTH, CHUNK);
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] op_sum;
    logic [WIDTH-1:0] op_carry;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_nxt;
    logic             cflop;
    logic             ovf_q;
    logic [CHUNK-1:0] s_chunk;
    logic             cout;
    logic             last;
    logic             skip;

    csa_chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a    (op_sum[idx*CHUNK +: CHUNK]),
        .b    (op_carry[idx*CHUNK +: CHUNK]),
        .cin  (cflop),
        .s    (s_chunk),
        .cout (cout)
    );

    assign last = (idx == IDXW'(NCH - 1));

`ifdef CSA_RESOLVE_ZERO_SKIP_EN
    logic [WIDTH-1:0] hi_mask;
    assign hi_mask = {WIDTH{1'b1}} << ((int'(idx) + 1) * CHUNK);
    // No carry leaving this chunk and no carry bits above it: upper sum bits are final.
    assign skip    = !cout && ((op_carry & hi_mask) == '0);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        res_nxt = res_q;
        res_nxt[idx*CHUNK +: CHUNK] = s_chunk;
`ifdef CSA_RESOLVE_ZERO_SKIP_EN
        if (skip) begin
            res_nxt = (res_nxt & ~hi_mask) | (op_sum & hi_mask);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            op_sum   <= '0;
            op_carry <= '0;
            res_q    <= '0;
            cflop    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_sum   <= in_sum;
                        op_carry <= in_carry;
                        cflop    <= 1'b0;
                        idx      <= '0;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    res_q <= res_nxt;
                    cflop <= cout;
                    idx   <= idx + IDXW'(1);
                    if (last || skip) begin
                        // A skip implies cout==0, so overflow reads as zero there.
                        ovf_q <= cout;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign out_result   = res_q;
    assign out_overflow = ovf_q;

endmodule
